// File: rtl/instr_encoder.sv
// Instruction encoder: packs requested fields into 32-bit instruction words,
// queues them in a 4-entry FIFO and streams them into instruction memory.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  op_sel_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ready_i,
    output logic        err_o,
    output logic [15:0] wr_count_o
);

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned WORD_W  = 32;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WORD_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              mem_we_d, err_d;
    logic [WORD_W-1:0] mem_data_d, mem_addr_d, enc_word;
    logic [15:0]       wr_count_d;
    logic [5:0]        opcode;
    logic              accept, push, complete;

    // Ready comes from registered occupancy; a flush in progress blocks intake.
    assign req_ready_o = ready_q & ~clear_i;
    assign accept      = req_valid_i & req_ready_o;
    assign push        = accept & (op_sel_i != 3'd7);
    assign complete    = (state_q == WRITE) & mem_ready_i;

    // Field packing for the three instruction formats.
    always_comb begin
        opcode   = 6'b000000;
        enc_word = '0;
        case (op_sel_i)
            3'd1:    opcode = 6'b001000;
            3'd2:    opcode = 6'b001010;
            3'd3:    opcode = 6'b100011;
            3'd4:    opcode = 6'b101011;
            3'd5:    opcode = 6'b000100;
            3'd6:    opcode = 6'b000010;
            default: opcode = 6'b000000;
        endcase
        case (op_sel_i)
            3'd0:    enc_word = {opcode, rs_i, rt_i, rd_i, shamt_i, funct_i};
            3'd6:    enc_word = {opcode, target_i};
            default: enc_word = {opcode, rs_i, rt_i, imm_i};
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ready_d    = ready_q;
        err_d      = 1'b0;
        mem_addr_d = mem_addr_o;
        wr_count_d = wr_count_o;
        mem_we_d   = 1'b0;
        mem_data_d = '0;

        if (clear_i) begin
            state_d    = IDLE;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            ready_d    = 1'b1;
            mem_addr_d = BASE_ADDR;
            wr_count_d = '0;
        end else begin
            err_d = accept & (op_sel_i == 3'd7);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (complete) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                mem_addr_d = mem_addr_o + WORD_W'(4);
                wr_count_d = (wr_count_o == 16'hFFFF) ? wr_count_o : wr_count_o + 16'd1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(complete);

            case (state_q)
                IDLE:    if (count_q != '0) state_d = WRITE;
                WRITE:   if (complete) state_d = (count_q > CNT_W'(1)) ? WRITE : IDLE;
                default: state_d = IDLE;
            endcase

            ready_d = (count_d < CNT_W'(DEPTH));
            if (state_d == WRITE) begin
                mem_we_d   = 1'b1;
                mem_data_d = fifo_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            err_o      <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_data_o <= '0;
            mem_addr_o <= BASE_ADDR;
            wr_count_o <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            err_o      <= err_d;
            mem_we_o   <= mem_we_d;
            mem_data_o <= mem_data_d;
            mem_addr_o <= mem_addr_d;
            wr_count_o <= wr_count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule
